id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the five-stage RISC-V core, with integrated load-use hazard detection and bubble insertion. It captures decoded operands and control from ID and presents them to EX. Its registered `id_ex_*` fields are the register-index and control inputs consumed by the EX-stage forwarding unit. It also drives the PC and IF/ID write enables that stall the front end when a load-use dependency cannot be covered by forwarding.

## Interface
- `XLEN`, 32: datapath width (operands, immediate, PC).
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `if_id_rs1`, `if_id_rs2` input 5 each: source register indices decoded in ID.
- `id_uses_rs2` input 1: the instruction reads rs2 (R-type, store, branch).
- `id_rd` input 5: destination register index.
- `id_regWrite`, `id_memRead`, `id_memWrite`, `id_memToReg`, `id_ALUSrcB` input 1 each: decoded control bits.
- `id_aluOp` input 4: ALU operation select.
- `id_rs1_data`, `id_rs2_data`, `id_imm`, `id_pc` input XLEN each: operands, immediate, PC.
- `flush` input 1: taken branch or jump resolved in EX; kill the instruction in ID.
- `ex_stall` input 1: downstream hold request; freeze the whole front end.
- `id_ex_*` output (widths as above): registered copies of every ID input, plus `id_ex_valid`. Includes `id_ex_reg_rs1` and `id_ex_reg_rs2`.
- `pc_write`, `if_id_write` output 1 each: front-end write enables.
- `load_use_stall` output 1: a load-use bubble is being inserted this cycle.
- `bubble_cnt` output 16: count of load-use bubbles (see Configuration).

## Operation
- **Hazard condition (combinational).** `hz` is asserted when all of the following hold:
  - `id_ex_memRead`, `id_ex_valid` and `id_valid` are set;
  - `id_ex_rd != 0`;
  - either `id_ex_rd == if_id_rs1`, or (`id_uses_rs2` and `id_ex_rd == if_id_rs2`).
- **Derived signals.**
  - `load_use_stall = hz & ~flush & ~ex_stall`.
  - `pc_write = if_id_write = ~(load_use_stall | ex_stall)`.
- **Register update priority** (evaluated each rising edge):
  1. `rst`: all `id_ex_*` cleared to 0. `bubble_cnt` cleared to 0.
  2. `flush`: bubble inserted. The flushed ID instruction is discarded.
  3. `ex_stall`: all `id_ex_*` hold their value.
  4. `load_use_stall`: bubble inserted.
  5. Otherwise: all `id_ex_*` load from the ID inputs, with `id_ex_valid = id_valid`.
- **Bubble definition.** These fields are set to 0: `id_ex_valid`, `id_ex_regWrite`, `id_ex_memRead`, `id_ex_memWrite`, `id_ex_memToReg`, `id_ex_rd`, `id_ex_reg_rs1`, `id_ex_reg_rs2`, `id_ex_aluOp`. Data fields are also zeroed. Because a bubble's sources are x0, the forwarding unit never matches on it.
- **Load with no dependent consumer.** No stall is raised.
- **Load to x0.** Never stalls.
- **Dependent instruction with `id_valid = 0`.** Never stalls.
- **`flush` together with `hz`.** Flush wins; `pc_write` stays 1 so the front end can redirect.
- **`ex_stall` together with `hz`.** The stage holds; `load_use_stall = 0`. The hazard is re-evaluated once `ex_stall` drops.

## Timing
- **Latency.** One cycle ID→EX: inputs sampled at edge N appear on `id_ex_*` in cycle N+1.
- **Load-use sequence:**
  - Cycle N: the load is in EX and the dependent instruction is in ID. `hz = 1`, `pc_write = 0`.
  - Edge N: a bubble enters EX and IF/ID holds.
  - Cycle N+1: `hz = 0` because `id_ex_memRead = 0`.
  - Edge N+1: the dependent instruction enters EX.
  - Cycle N+2: the forwarding unit sees the load in MEM/WB and selects the MEM path (01).
- **Stall length.** Exactly one bubble per load-use pair. Back-to-back load-use pairs each cost one bubble.
- **Combinational outputs.** `pc_write`, `if_id_write` and `load_use_stall` depend only on current registers and inputs. They have no edge latency.
- **Reset values.**
  - All `id_ex_*` are 0.
  - `bubble_cnt` is 0.
  - `pc_write` and `if_id_write` are 1, provided `ex_stall = 0`.
  - `load_use_stall` is 0.
- **Reset mid-stall.** Reset clears state. No stall is carried across reset.

## Configuration
- **`ID_EX_BUBBLE_CNT_EN` defined:** `bubble_cnt` is a 16-bit register that increments on every edge where `load_use_stall = 1`.
  - It saturates at 16'hFFFF.
  - Flush bubbles are not counted.
- **`ID_EX_BUBBLE_CNT_EN` undefined:** no counter logic. `bubble_cnt` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- **Reset.** Hold `rst` 2 cycles with random inputs → all `id_ex_*` are 0, `pc_write = 1`, `bubble_cnt = 0`.
- **Load-use on rs1.** `lw x5` followed by `add x6,x5,x7` → exactly one cycle of `load_use_stall = 1` and `pc_write = 0`. The bubble has `id_ex_rd = 0` and `id_ex_regWrite = 0`. The add reaches EX two cycles after the load. With the macro defined, `bubble_cnt = 1`.
- **Non-stalling cases.**
  - `lw x0` then `add x1,x0,x0` → no stall.
  - `lw x5` then `addi x6,x8,1`, with `id_uses_rs2 = 0` and `if_id_rs2 = 5` → no stall.
- **Flush precedence.** `hz` and `flush` asserted in the same cycle → bubble inserted, `pc_write = 1`, `load_use_stall = 0`, `bubble_cnt` unchanged.
- **Downstream hold.** `ex_stall` held 3 cycles during a load-use pair → `id_ex_*` stable for all 3 cycles and `pc_write = 0`. Exactly one bubble follows `ex_stall` deassertion.
- **Counter saturation** (macro defined). Force `bubble_cnt` to 16'hFFFE, then cause 3 load-use stalls → reads 16'hFFFF. With the macro undefined, it stays 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the five-stage RISC-V core. It also detects
// load-use hazards and inserts a single bubble when forwarding cannot cover
// the dependency.
//
// Optional feature macro: ID_EX_BUBBLE_CNT_EN
//   defined   : bubble_cnt is a saturating 16-bit count of load-use bubbles
//   undefined : bubble_cnt is tied to zero, no counter logic is built
//
// Ports
//   clk, rst                 core clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   if_id_rs1/rs2            source register indices decoded in ID
//   id_uses_rs2              instruction reads rs2
//   id_rd                    destination register index
//   id_regWrite .. id_ALUSrcB decoded control bits
//   id_aluOp                 ALU operation select
//   id_rs1_data .. id_pc     operands, immediate and PC (XLEN wide)
//   flush                    branch/jump redirect resolved in EX
//   ex_stall                 downstream hold request
//   id_ex_*                  registered copies of the ID inputs
//   pc_write, if_id_write    front-end write enables
//   load_use_stall           a load-use bubble is inserted this cycle
//   bubble_cnt               load-use bubble count
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      if_id_rs1,
    input  logic [4:0]      if_id_rs2,
    input  logic            id_uses_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_regWrite,
    input  logic            id_memRead,
    input  logic            id_memWrite,
    input  logic            id_memToReg,
    input  logic            id_ALUSrcB,
    input  logic [3:0]      id_aluOp,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            flush,
    input  logic            ex_stall,
    output logic            id_ex_valid,
    output logic [4:0]      id_ex_reg_rs1,
    output logic [4:0]      id_ex_reg_rs2,
    output logic            id_ex_uses_rs2,
    output logic [4:0]      id_ex_rd,
    output logic            id_ex_regWrite,
    output logic            id_ex_memRead,
    output logic            id_ex_memWrite,
    output logic            id_ex_memToReg,
    output logic            id_ex_ALUSrcB,
    output logic [3:0]      id_ex_aluOp,
    output logic [XLEN-1:0] id_ex_rs1_data,
    output logic [XLEN-1:0] id_ex_rs2_data,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [XLEN-1:0] id_ex_pc,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            load_use_stall,
    output logic [15:0]     bubble_cnt
);

    logic hz;
    logic insert_bubble;

    // A valid load in EX whose nonzero destination is read by a valid
    // instruction in ID: its data is not available for forwarding yet.
    assign hz = id_ex_valid && id_ex_memRead && id_valid && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == if_id_rs1) || (id_uses_rs2 && (id_ex_rd == if_id_rs2)));

    // A flush already kills the dependent instruction, and a downstream hold
    // freezes everything; in both cases the hazard is not acted on now.
    assign load_use_stall = hz && !flush && !ex_stall;
    assign pc_write       = !(load_use_stall || ex_stall);
    assign if_id_write    = !(load_use_stall || ex_stall);

    // Reset, flush and load-use bubbles all leave an all-zero stage. Flush
    // outranks ex_stall; load_use_stall is already inactive under ex_stall.
    assign insert_bubble = rst || flush || load_use_stall;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk) begin
        if (insert_bubble) begin
            id_ex_valid    <= 1'b0;
            id_ex_reg_rs1  <= 5'd0;
            id_ex_reg_rs2  <= 5'd0;
            id_ex_uses_rs2 <= 1'b0;
            id_ex_rd       <= 5'd0;
            id_ex_regWrite <= 1'b0;
            id_ex_memRead  <= 1'b0;
            id_ex_memWrite <= 1'b0;
            id_ex_memToReg <= 1'b0;
            id_ex_ALUSrcB  <= 1'b0;
            id_ex_aluOp    <= 4'd0;
            id_ex_rs1_data <= '0;
            id_ex_rs2_data <= '0;
            id_ex_imm      <= '0;
            id_ex_pc       <= '0;
        end else if (!ex_stall) begin
            id_ex_valid    <= id_valid;
            id_ex_reg_rs1  <= if_id_rs1;
            id_ex_reg_rs2  <= if_id_rs2;
            id_ex_uses_rs2 <= id_uses_rs2;
            id_ex_rd       <= id_rd;
            id_ex_regWrite <= id_regWrite;
            id_ex_memRead  <= id_memRead;
            id_ex_memWrite <= id_memWrite;
            id_ex_memToReg <= id_memToReg;
            id_ex_ALUSrcB  <= id_ALUSrcB;
            id_ex_aluOp    <= id_aluOp;
            id_ex_rs1_data <= id_rs1_data;
            id_ex_rs2_data <= id_rs2_data;
            id_ex_imm      <= id_imm;
            id_ex_pc       <= id_pc;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] cnt_q;

    // Counts only load-use bubbles; flush bubbles never raise load_use_stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else if (load_use_stall && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign bubble_cnt = cnt_q;
`else
    assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int XLEN = 32;
`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic            valid;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            uses_rs2;
        logic [4:0]      rd;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            memToReg;
        logic            ALUSrcB;
        logic [3:0]      aluOp;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } ex_t;

    logic clk = 1'b0;
    logic rst, id_valid, id_uses_rs2, flush, ex_stall;
    logic [4:0] if_id_rs1, if_id_rs2, id_rd;
    logic id_regWrite, id_memRead, id_memWrite, id_memToReg, id_ALUSrcB;
    logic [3:0] id_aluOp;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;

    logic id_ex_valid, id_ex_uses_rs2, id_ex_regWrite, id_ex_memRead;
    logic id_ex_memWrite, id_ex_memToReg, id_ex_ALUSrcB;
    logic [4:0] id_ex_reg_rs1, id_ex_reg_rs2, id_ex_rd;
    logic [3:0] id_ex_aluOp;
    logic [XLEN-1:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc;
    logic pc_write, if_id_write, load_use_stall;
    logic [15:0] bubble_cnt;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_ALUSrcB(id_ALUSrcB),
        .id_aluOp(id_aluOp), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .ex_stall(ex_stall),
        .id_ex_valid(id_ex_valid), .id_ex_reg_rs1(id_ex_reg_rs1),
        .id_ex_reg_rs2(id_ex_reg_rs2), .id_ex_uses_rs2(id_ex_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_regWrite(id_ex_regWrite),
        .id_ex_memRead(id_ex_memRead), .id_ex_memWrite(id_ex_memWrite),
        .id_ex_memToReg(id_ex_memToReg), .id_ex_ALUSrcB(id_ex_ALUSrcB),
        .id_ex_aluOp(id_ex_aluOp), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: contents of the EX slot and the bubble counter.
    ex_t  m_ex;
    int   m_cnt;
    logic last_lus, last_pcw;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t observed();
        ex_t o;
        o = '{id_ex_valid, id_ex_reg_rs1, id_ex_reg_rs2, id_ex_uses_rs2, id_ex_rd,
              id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_memToReg,
              id_ex_ALUSrcB, id_ex_aluOp, id_ex_rs1_data, id_ex_rs2_data,
              id_ex_imm, id_ex_pc};
        return o;
    endfunction

    function automatic ex_t from_id();
        ex_t n;
        n = '{id_valid, if_id_rs1, if_id_rs2, id_uses_rs2, id_rd, id_regWrite,
              id_memRead, id_memWrite, id_memToReg, id_ALUSrcB, id_aluOp,
              id_rs1_data, id_rs2_data, id_imm, id_pc};
        return n;
    endfunction

    // Does the ID instruction need the result of a load still sitting in EX?
    function automatic bit ref_hazard();
        bit reads_it;
        if (!(m_ex.valid && m_ex.memRead && id_valid) || m_ex.rd == 5'd0) return 1'b0;
        reads_it = (if_id_rs1 == m_ex.rd);
        if (id_uses_rs2 && if_id_rs2 == m_ex.rd) reads_it = 1'b1;
        return reads_it;
    endfunction

    // Called at a negedge with inputs already applied; ends at the next negedge.
    task automatic step();
        bit exp_lus;
        #1;
        exp_lus = ref_hazard() && !flush && !ex_stall;
        last_lus = load_use_stall;
        last_pcw = pc_write;
        check("load_use_stall", load_use_stall, exp_lus);
        check("pc_write", pc_write, !(exp_lus || ex_stall));
        check("if_id_write", if_id_write, !(exp_lus || ex_stall));
        if (rst) begin
            m_ex = '0;
            m_cnt = 0;
        end else if (flush) begin
            m_ex = '0;
        end else if (ex_stall) begin
            m_ex = m_ex;
        end else if (exp_lus) begin
            m_ex = '0;
            if (CNT_EN && m_cnt < 65535) m_cnt++;
        end else begin
            m_ex = from_id();
        end
        @(negedge clk);
        check("id_ex", observed(), m_ex);
        check("bubble_cnt", bubble_cnt, m_cnt[15:0]);
    endtask

    task automatic drive_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] rd,
                               input logic mr, input logic rw);
        id_valid    = v;
        if_id_rs1   = rs1;
        if_id_rs2   = rs2;
        id_uses_rs2 = u2;
        id_rd       = rd;
        id_memRead  = mr;
        id_regWrite = rw;
        id_memWrite = 1'b0;
        id_memToReg = mr;
        id_ALUSrcB  = 1'($urandom);
        id_aluOp    = 4'($urandom);
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_pc       = $urandom;
    endtask

    task automatic randomize_inputs();
        drive_instr(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        id_memWrite = 1'($urandom);
    endtask

    // lw x5 followed by add x6,x5,x7
    task automatic load_use_pair();
        drive_instr(1, 5'd1, 5'd2, 0, 5'd5, 1, 1);
        step();
        drive_instr(1, 5'd5, 5'd7, 1, 5'd6, 0, 1);
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
        randomize_inputs();
        @(negedge clk);
        m_ex = '0;
        m_cnt = 0;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            step();
            check("reset_id_ex", observed(), ex_t'(0));
            check("reset_pc_write", last_pcw, 1'b1);
            check("reset_cnt", bubble_cnt, 16'h0000);
        end
        rst = 1'b0;

        // Load-use on rs1: one bubble, then the add enters EX.
        load_use_pair();
        check("lu_stall", last_lus, 1'b1);
        check("lu_pc_write", last_pcw, 1'b0);
        check("lu_bubble_rd", id_ex_rd, 5'd0);
        check("lu_bubble_regwrite", id_ex_regWrite, 1'b0);
        check("lu_cnt", bubble_cnt, CNT_EN ? 16'd1 : 16'd0);
        step();
        check("lu_no_second_stall", last_lus, 1'b0);
        check("lu_add_in_ex", id_ex_rd, 5'd6);
        check("lu_add_valid", id_ex_valid, 1'b1);

        // Load to x0 never stalls.
        drive_instr(1, 5'd1, 5'd2, 0, 5'd0, 1, 1);
        step();
        drive_instr(1, 5'd0, 5'd0, 1, 5'd1, 0, 1);
        step();
        check("x0_no_stall", last_lus, 1'b0);

        // rs2 match while rs2 is unused does not stall.
        drive_instr(1, 5'd1, 5'd2, 0, 5'd5, 1, 1);
        step();
        drive_instr(1, 5'd8, 5'd5, 0, 5'd6, 0, 1);
        step();
        check("rs2_unused_no_stall", last_lus, 1'b0);

        // Dependent instruction with id_valid=0 never stalls.
        drive_instr(1, 5'd1, 5'd2, 0, 5'd5, 1, 1);
        step();
        drive_instr(0, 5'd5, 5'd5, 1, 5'd6, 0, 1);
        step();
        check("invalid_no_stall", last_lus, 1'b0);

        // Flush outranks the hazard.
        drive_instr(1, 5'd1, 5'd2, 0, 5'd5, 1, 1);
        step();
        drive_instr(1, 5'd3, 5'd5, 1, 5'd6, 0, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_no_stall", last_lus, 1'b0);
        check("flush_pc_write", last_pcw, 1'b1);
        check("flush_bubble", observed(), ex_t'(0));
        check("flush_cnt", bubble_cnt, CNT_EN ? 16'd1 : 16'd0);

        // Downstream hold for 3 cycles during a load-use pair.
        drive_instr(1, 5'd1, 5'd2, 0, 5'd5, 1, 1);
        step();
        drive_instr(1, 5'd5, 5'd7, 1, 5'd6, 0, 1);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rd", id_ex_rd, 5'd5);
            check("hold_pc_write", last_pcw, 1'b0);
            check("hold_no_lus", last_lus, 1'b0);
        end
        ex_stall = 1'b0;
        step();
        check("hold_then_bubble", last_lus, 1'b1);
        check("hold_bubble_valid", id_ex_valid, 1'b0);
        step();
        check("hold_one_bubble_only", last_lus, 1'b0);
        check("hold_add_in_ex", id_ex_rd, 5'd6);

        // Counter saturation.
`ifdef ID_EX_BUBBLE_CNT_EN
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
`endif
        for (int i = 0; i < 3; i++) load_use_pair();
        check("cnt_saturate", bubble_cnt, CNT_EN ? 16'hFFFF : 16'h0000);

        // Reset in the middle of a load-use pair.
        drive_instr(1, 5'd1, 5'd2, 0, 5'd5, 1, 1);
        step();
        drive_instr(1, 5'd5, 5'd7, 1, 5'd6, 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_cleared", observed(), ex_t'(0));
        step();
        check("midreset_no_stall", last_lus, 1'b0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            rst      = ($urandom_range(0, 63) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            ex_stall = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
